// File: rtl/fixed_point_pkg.sv
// Shared definitions for the ODE datapath fixed-point divider:
// default word/fraction widths, FSM state encoding, saturation constants
// and the per-operation context captured when a division is accepted.
package fixed_point_pkg;

    localparam int N_DEF    = 16;
    localparam int FRAC_DEF = 8;

    // Saturation limits at the default word width
    localparam logic [N_DEF-1:0] MAX_POS = {1'b0, {(N_DEF-1){1'b1}}};
    localparam logic [N_DEF-1:0] MIN_NEG = {1'b1, {(N_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Sign and special-case information captured at accept time
    typedef struct packed {
        logic q_neg;     // quotient sign: sign(dividend) ^ sign(divisor)
        logic dvd_neg;   // dividend sign, picks the div-by-zero saturation rail
        logic div_zero;  // divisor was zero
    } div_ctx_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// W-bit carry-lookahead adder/subtractor. Bits are grouped in GRP-bit
// blocks; each block forms group generate/propagate terms and block carries
// are chained by lookahead. In subtract mode b is inverted and carry-in is 1.
// 'negative' is the MSB of the two's-complement result.
module carry_lookahead_adder #(
    parameter int W   = 17,
    parameter int GRP = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_subtract,
    output logic [W-1:0] sum,
    output logic         negative
);

    localparam int NG = (W + GRP - 1) / GRP;

    logic [W-1:0]  bx;
    logic [W-1:0]  p;
    logic [W-1:0]  g;
    logic [W:0]    c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;

    assign bx = is_subtract ? ~b : b;
    assign p  = a ^ bx;
    assign g  = a & bx;

    // Group generate/propagate, block carry chain, then in-block carries
    always_comb begin
        c     = '0;
        gg    = '0;
        gp    = '0;
        gc    = '0;
        gc[0] = is_subtract;
        for (int k = 0; k < NG; k++) begin
            gp[k] = 1'b1;
            for (int j = 0; j < GRP; j++) begin
                if (k*GRP + j < W) begin
                    gg[k] = g[k*GRP + j] | (p[k*GRP + j] & gg[k]);
                    gp[k] = gp[k] & p[k*GRP + j];
                end
            end
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
            for (int j = 0; j < GRP; j++) begin
                if (k*GRP + j < W) begin
                    if (j == 0)
                        c[k*GRP] = gc[k];
                    else
                        c[k*GRP + j] = g[k*GRP + j - 1] | (p[k*GRP + j - 1] & c[k*GRP + j - 1]);
                end
            end
        end
        c[W] = gc[NG];
    end

    assign sum      = p ^ c[W-1:0];
    assign negative = sum[W-1];

endmodule

// File: rtl/fixed_point_divider.sv
// Multi-cycle signed Q(N-FRAC).FRAC divider for the ODE datapath.
// Restoring division, one quotient bit per cycle, with the trial subtraction
// done by carry_lookahead_adder. start/busy/done handshake; the result
// saturates and reports divide-by-zero and overflow.
// Optional build macro ROUND_NEAREST_EN: round the quotient magnitude
// half-away-from-zero instead of truncating toward zero.
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_div_by_zero,
    output logic         o_overflow
);

    localparam int QW = N + FRAC;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
    localparam logic [N-1:0]  SAT_POS  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  SAT_NEG  = {1'b1, {(N-1){1'b0}}};

    div_state_e    state;
    div_ctx_t      ctx;
    logic [CW-1:0] cnt;
    logic [QW-1:0] num;
    logic [QW-1:0] quo;
    logic [N-1:0]  rem;
    logic [N-1:0]  dvs;

    logic [N:0]    rem_shift;
    logic [N:0]    trial;
    logic          trial_neg;
    logic          unused_trial_msb;

    logic [QW:0]   q_mag;
    logic [QW:0]   q_lim;
    logic [N-1:0]  fix_q;
    logic          fix_ovf;

    // Unsigned magnitude; the most-negative value maps to 2^(N-1)
    function automatic logic [N-1:0] mag(input logic [N-1:0] v);
        return v[N-1] ? (~v + 1'b1) : v;
    endfunction

    // Remainder shifted left with the next numerator bit, minus |divisor|
    assign rem_shift = {rem, num[QW-1]};

    carry_lookahead_adder #(.W(N+1)) u_trial (
        .a           (rem_shift),
        .b           ({1'b0, dvs}),
        .is_subtract (1'b1),
        .sum         (trial),
        .negative    (trial_neg)
    );

    // A non-negative trial is below |divisor| <= 2^(N-1), so its MSB is
    // redundant with 'negative'
    assign unused_trial_msb = trial[N];

    // Final quotient: optional rounding, saturation, sign application
    always_comb begin
        q_mag = {1'b0, quo};
`ifdef ROUND_NEAREST_EN
        if ({1'b0, rem, 1'b0} >= {2'b00, dvs})
            q_mag = q_mag + 1'b1;
`endif
        q_lim   = ctx.q_neg ? (QW+1)'(SAT_NEG) : (QW+1)'(SAT_POS);
        fix_ovf = 1'b0;
        fix_q   = '0;
        if (ctx.div_zero) begin
            fix_q = ctx.dvd_neg ? SAT_NEG : SAT_POS;
        end else if (q_mag > q_lim) begin
            fix_ovf = 1'b1;
            fix_q   = ctx.q_neg ? SAT_NEG : SAT_POS;
        end else begin
            fix_q = ctx.q_neg ? (~q_mag[N-1:0] + 1'b1) : q_mag[N-1:0];
        end
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            ctx           <= '0;
            cnt           <= '0;
            num           <= '0;
            quo           <= '0;
            rem           <= '0;
            dvs           <= '0;
            o_quotient    <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    o_busy <= i_start;
                    if (i_start) begin
                        ctx.q_neg    <= i_dividend[N-1] ^ i_divisor[N-1];
                        ctx.dvd_neg  <= i_dividend[N-1];
                        ctx.div_zero <= (i_divisor == '0);
                        dvs          <= mag(i_divisor);
                        num          <= {mag(i_dividend), {FRAC{1'b0}}};
                        rem          <= '0;
                        quo          <= '0;
                        cnt          <= CNT_LAST;
                        state        <= (i_divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    num <= {num[QW-2:0], 1'b0};
                    quo <= {quo[QW-2:0], ~trial_neg};
                    rem <= trial_neg ? rem_shift[N-1:0] : trial[N-1:0];
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    o_quotient    <= fix_q;
                    o_overflow    <= fix_ovf;
                    o_div_by_zero <= ctx.div_zero;
                    state         <= DONE;
                end
                DONE: begin
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: directed cases plus random
// operands checked against an integer-arithmetic reference model.
module tb_fixed_point_divider;

    localparam int N    = 16;
    localparam int FRAC = 8;
    localparam longint MAXV = (longint'(1) << (N-1)) - 1;
    localparam longint MINV = -(longint'(1) << (N-1));
`ifdef ROUND_NEAREST_EN
    localparam logic [15:0] Q_2_3 = 16'h00AB;
`else
    localparam logic [15:0] Q_2_3 = 16'h00AA;
`endif

    typedef struct {
        logic [15:0] q;
        logic        dz;
        logic        ov;
        int          start_cyc;
        int          lat;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_dividend = '0;
    logic [15:0] i_divisor = '0;
    logic [15:0] o_quotient;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;
    logic        o_overflow;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   prev_done = 1'b0;
    exp_t sb_q[$];

    // Directed cases: dividend, divisor, expected quotient / div0 / overflow
    logic [15:0] d_a  [8] = '{16'h0300, 16'hFD00, 16'hFD00, 16'h0100, 16'hFF00, 16'h7F00, 16'h8000, 16'h0200};
    logic [15:0] d_b  [8] = '{16'h0200, 16'h0200, 16'hFE00, 16'h0000, 16'h0000, 16'h0080, 16'h0100, 16'h0300};
    logic [15:0] d_q  [8] = '{16'h0180, 16'hFE80, 16'h0180, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, Q_2_3};
    logic        d_dz [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        d_ov [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    fixed_point_divider #(.N(N), .FRAC(FRAC)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_quotient    (o_quotient),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero),
        .o_overflow    (o_overflow)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact rational quotient via integer arithmetic, then
    // rounding rule, saturation to the N-bit signed range
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint sa, sb, num, den, m, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.q = '0; e.dz = 1'b0; e.ov = 1'b0; e.start_cyc = 0; e.lat = 0;
        if (sb == 0) begin
            e.dz = 1'b1;
            e.q  = (sa < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
            num = (sa < 0 ? -sa : sa) << FRAC;
            den = (sb < 0) ? -sb : sb;
            m   = num / den;
`ifdef ROUND_NEAREST_EN
            if (2 * (num % den) >= den) m = m + 1;
`endif
            v = ((sa < 0) != (sb < 0)) ? -m : m;
            if (v > MAXV) begin
                e.q = 16'h7FFF; e.ov = 1'b1;
            end else if (v < MINV) begin
                e.q = 16'h8000; e.ov = 1'b1;
            end else begin
                e.q = 16'(v);
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input exp_t e, input bit push);
        exp_t x;
        x = e;
        @(negedge i_clk);
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        if (push) begin
            x.start_cyc = cyc;
            x.lat       = (b == 16'h0000) ? 2 : N + FRAC + 2;
            sb_q.push_back(x);
        end
        // operands are don't-care once accepted
        i_dividend = 16'($urandom);
        i_divisor  = 16'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge i_clk);
        while (o_busy && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        if (o_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: o_busy still 1 after %0d cycles", k);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_quotient"}, 32'(o_quotient), 32'h0);
        chk({tag, "_busy"}, 32'(o_busy), 32'h0);
        chk({tag, "_done"}, 32'(o_done), 32'h0);
        chk({tag, "_div_by_zero"}, 32'(o_div_by_zero), 32'h0);
        chk({tag, "_overflow"}, 32'(o_overflow), 32'h0);
    endtask

    // Monitor: pop expected result on every done pulse
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            if (prev_done)
                chk("done_pulse_width", 32'(o_done), 32'h0);
            if (o_done) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with quotient %0h, expected no result", o_quotient);
                end else begin
                    e = sb_q.pop_front();
                    chk("quotient", 32'(o_quotient), 32'(e.q));
                    chk("div_by_zero", 32'(o_div_by_zero), 32'(e.dz));
                    chk("overflow", 32'(o_overflow), 32'(e.ov));
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    chk("busy_at_done", 32'(o_busy), 32'h1);
                end
            end
        end
        prev_done = o_done && !i_rst;
    end

    initial begin
        exp_t e;
        logic [15:0] a, b;
        int mode;

        // Reset state
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        // Directed cases with hand-derived expectations
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            e.q = d_q[i]; e.dz = d_dz[i]; e.ov = d_ov[i]; e.start_cyc = 0; e.lat = 0;
            issue(d_a[i], d_b[i], e, 1'b1);
        end

        // Start pulsed during a busy operation must be ignored
        wait_idle();
        e = model(16'h0300, 16'h0200);
        issue(16'h0300, 16'h0200, e, 1'b1);
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        i_dividend = 16'h1234;
        i_divisor  = 16'h0001;
        i_start    = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_idle();
        repeat (30) @(negedge i_clk);

        // Reset mid-operation: outputs cleared, no done pulse afterwards
        issue(16'h0500, 16'h0300, e, 1'b0);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk_reset_outputs("midop_reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (35) @(negedge i_clk);
        chk("post_reset_idle_busy", 32'(o_busy), 32'h0);

        // New start after abort completes normally
        e = model(16'hFD00, 16'h0200);
        issue(16'hFD00, 16'h0200, e, 1'b1);

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            wait_idle();
            mode = $urandom_range(0, 9);
            a = 16'($urandom);
            if (mode == 0)
                b = 16'h0000;
            else if (mode <= 3)
                b = ($urandom_range(0, 1) == 1) ? (16'h0000 - 16'($urandom_range(1, 255))) : 16'($urandom_range(1, 255));
            else
                b = 16'($urandom);
            e = model(a, b);
            issue(a, b, e, 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge i_clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
Multi-cycle signed fixed-point divider for the ODE datapath: computes quotient = dividend / divisor in the same two's-complement Q format as the adder.
- Arithmetic inverse companion of carry_lookahead_adder: restoring division, one quotient bit per cycle, using that adder in subtract mode for the trial subtraction.
- start/busy/done handshake toward the ODE step controller; saturating result with div-by-zero and overflow flags.

Parameters:
N, 16, operand/result word width (two's complement)
FRAC, 8, fractional bits of operands and result (Q(N-FRAC).FRAC)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  request; sampled only in IDLE
i_dividend  input  N  signed dividend, captured when start accepted
i_divisor  input  N  signed divisor, captured when start accepted
o_quotient  output  N  signed quotient, held until next accepted start
o_busy  output  1  high from cycle after accept until o_done cycle inclusive
o_done  output  1  one-cycle pulse, o_quotient/flags valid
o_div_by_zero  output  1  divisor was 0; held with o_quotient
o_overflow  output  1  quotient saturated; held with o_quotient

Behaviour:
- Reset: state IDLE; o_quotient=0, o_busy=0, o_done=0, o_div_by_zero=0, o_overflow=0; iteration counter and internal registers cleared. Reset mid-operation aborts, returns to IDLE with no o_done pulse.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: on i_start=1, capture operands, record sign = sign(dividend) XOR sign(divisor), store magnitudes (|most-negative| = 2^(N-1), held unsigned N bits), load numerator = |dividend| << FRAC (N+FRAC bits), remainder=0, counter=N+FRAC-1. Divisor==0 -> go to FIX directly; else -> CALC.
- CALC: each cycle shift remainder left by one, bringing in next numerator MSB; trial = remainder - |divisor| on N+1 bits (carry_lookahead_adder, is_subtract=1); trial negative -> keep remainder, quotient bit 0; else remainder=trial, bit 1. After N+FRAC cycles (counter==0) -> FIX.
- FIX: unsigned magnitude Q (N+FRAC bits). Positive limit 2^(N-1)-1, negative limit 2^(N-1). Magnitude above limit -> saturate to 0x7FFF.../0x8000..., o_overflow=1. Divisor zero -> o_quotient = 2^(N-1)-1 if dividend>=0 else -2^(N-1), o_div_by_zero=1, o_overflow=0. Otherwise apply sign. Register outputs -> DONE.
- DONE: o_done=1 for this cycle only -> IDLE.
- Latency: non-zero divisor: o_done high exactly N+FRAC+2 cycles after the start-sampling edge (26 for defaults). Zero divisor: 2 cycles.
- i_start while busy (not IDLE): ignored, no queuing; operand changes after accept have no effect.
- Rounding default: truncation toward zero; quotient of 0 is never negative-signed (-0 -> 0).

Optional Feature:
ROUND_NEAREST_EN
- Defined: FIX rounds magnitude half-away-from-zero; increment Q when 2*remainder >= |divisor|; saturation check applied after the increment. Latency unchanged.
- Undefined: truncation toward zero, no increment logic.

Decomposition:
- Shared package fixed_point_pkg: N/FRAC defaults, state enum (IDLE, CALC, FIX, DONE), MAX_POS/MIN_NEG constants.
- Sub-module: carry_lookahead_adder instantiated at width N+1 for trial subtraction; its negative output selects restore.
- FSM, counter, and shift registers stay in this module.

Test Plan:
- 0x0300 / 0x0200 (3.0/2.0) -> o_quotient=0x0180, flags 0, o_done exactly 26 cycles after start, o_busy high through that cycle.
- 0xFD00 / 0x0200 (-3.0/2.0) -> 0xFE80; 0xFD00 / 0xFE00 -> 0x0180.
- 0x0100 / 0x0000 -> 0x7FFF, o_div_by_zero=1, done at 2 cycles; 0xFF00 / 0 -> 0x8000, o_div_by_zero=1.
- 0x7F00 / 0x0080 (127/0.5) -> 0x7FFF, o_overflow=1; 0x8000 / 0x0100 -> 0x8000, no overflow.
- 0x0200 / 0x0300 -> 0x00AA without macro, 0x00AB with ROUND_NEAREST_EN.
- Start pulsed at cycle 5 of busy operation: ignored, first result intact. i_rst at cycle 10: outputs 0, no done pulse. New start then completes normally.
